// File: rtl/ibex_csr_access_arb.sv
// Round-robin arbiter and read-check-modify-write sequencer that shares a CSR bank between the core and debug ports.
// Latency: grant in G, write enable in G+2, response in G+3 (one access per 4 cycles); no response backpressure, and requests arriving while busy wait for IDLE.
module ibex_csr_access_arb #(
    parameter int NumCsr = 4,
    parameter int Width  = 32,
    parameter int AddrW  = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    core_req_i,
    input  logic [AddrW-1:0]        core_addr_i,
    input  logic [1:0]              core_op_i,
    input  logic [Width-1:0]        core_wdata_i,
    output logic                    core_gnt_o,
    output logic                    core_rvalid_o,

    input  logic                    dbg_req_i,
    input  logic [AddrW-1:0]        dbg_addr_i,
    input  logic [1:0]              dbg_op_i,
    input  logic [Width-1:0]        dbg_wdata_i,
    output logic                    dbg_gnt_o,
    output logic                    dbg_rvalid_o,

    output logic [Width-1:0]        rdata_o,
    output logic                    err_o,

    output logic [NumCsr-1:0]       csr_wr_en_o,
    output logic [Width-1:0]        csr_wr_data_o,
    input  logic [NumCsr*Width-1:0] csr_rd_data_i,
    input  logic [NumCsr-1:0]       csr_rd_error_i,

    output logic                    alert_o,
    output logic                    busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [AddrW:0] NUM_CSR_W = (AddrW+1)'(NumCsr);

    if (NumCsr < 2 || (2 ** AddrW) <= NumCsr) begin : g_bad_params
        $error("ibex_csr_access_arb: need NumCsr >= 2 and 2**AddrW > NumCsr");
    end

    state_e             r_state;
    state_e             w_state_nxt;
    logic               r_owner_dbg;
    logic               r_last_dbg;
    logic [AddrW-1:0]   r_addr;
    logic [1:0]         r_op;
    logic [Width-1:0]   r_wdata;
    logic [Width-1:0]   r_old;
    logic               r_shadow_err;

    logic               w_idle;
    logic               w_core_win;
    logic               w_dbg_win;
    logic               w_any_gnt;
    logic               w_in_range;
    logic [Width-1:0]   w_rd_sel;
    logic               w_rd_err_sel;
    logic [Width-1:0]   w_new_val;
    logic               w_wr_suppress;
    logic               w_wr_fire;

    assign w_idle = (r_state == S_IDLE);

    // Tie goes to whichever side was not granted last; a lone requester always wins.
    assign w_core_win = core_req_i & (~dbg_req_i | r_last_dbg);
    assign w_dbg_win  = dbg_req_i & ~w_core_win;

    // Gate with reset so nothing is granted while reset is held.
    assign core_gnt_o = rst_ni & w_idle & w_core_win;
    assign dbg_gnt_o  = rst_ni & w_idle & w_dbg_win;
    assign w_any_gnt  = core_gnt_o | dbg_gnt_o;

    assign w_in_range = ({1'b0, r_addr} < NUM_CSR_W);

    always_comb begin
        w_rd_sel     = '0;
        w_rd_err_sel = 1'b0;
        for (int i = 0; i < NumCsr; i++) begin
            if (r_addr == AddrW'(i)) begin
                w_rd_sel     = csr_rd_data_i[i*Width +: Width];
                w_rd_err_sel = csr_rd_error_i[i];
            end
        end
    end

    always_comb begin
        w_new_val = r_wdata;
        unique case (r_op)
            OP_READ:  w_new_val = r_old;
            OP_WRITE: w_new_val = r_wdata;
            OP_SET:   w_new_val = r_old | r_wdata;
            OP_CLEAR: w_new_val = r_old & ~r_wdata;
            default:  w_new_val = r_wdata;
        endcase
    end

    // A zero mask on SET/CLEAR would rewrite the same value, so it is not issued.
    assign w_wr_suppress = (r_op == OP_READ)
                         | (((r_op == OP_SET) | (r_op == OP_CLEAR)) & (r_wdata == '0))
                         | ~w_in_range
                         | r_shadow_err;

    assign w_wr_fire = (r_state == S_WRITE) & ~w_wr_suppress;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_any_gnt) w_state_nxt = S_READ;
            S_READ:  w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner_dbg  <= 1'b0;
            r_last_dbg   <= 1'b1;
            r_addr       <= '0;
            r_op         <= OP_READ;
            r_wdata      <= '0;
            r_old        <= '0;
            r_shadow_err <= 1'b0;
        end else begin
            if (w_any_gnt) begin
                r_owner_dbg <= w_dbg_win;
                r_last_dbg  <= w_dbg_win;
                r_addr      <= w_dbg_win ? dbg_addr_i  : core_addr_i;
                r_op        <= w_dbg_win ? dbg_op_i    : core_op_i;
                r_wdata     <= w_dbg_win ? dbg_wdata_i : core_wdata_i;
            end
            if (r_state == S_READ) begin
                r_old        <= w_in_range ? w_rd_sel : '0;
                r_shadow_err <= w_in_range & w_rd_err_sel;
            end
        end
    end

    always_comb begin
        csr_wr_en_o = '0;
        for (int i = 0; i < NumCsr; i++) begin
            csr_wr_en_o[i] = w_wr_fire & (r_addr == AddrW'(i));
        end
    end

    assign csr_wr_data_o = w_wr_fire ? w_new_val : '0;

    assign core_rvalid_o = (r_state == S_RESP) & ~r_owner_dbg;
    assign dbg_rvalid_o  = (r_state == S_RESP) &  r_owner_dbg;
    assign rdata_o       = (r_state == S_RESP) ? r_old : '0;
    assign err_o         = (r_state == S_RESP) & (~w_in_range | r_shadow_err);
    assign alert_o       = (r_state == S_RESP) & r_shadow_err;
    assign busy_o        = ~w_idle;

endmodule

// File: tb/tb_ibex_csr_access_arb.sv
// Bench for ibex_csr_access_arb: vector table of single accesses plus round-robin and mid-op reset sequences.
module tb_ibex_csr_access_arb;

    localparam int NumCsr = 4;
    localparam int Width  = 32;
    localparam int AddrW  = 3;

    logic                    clk;
    logic                    rst_ni;
    logic                    core_req_i, dbg_req_i;
    logic [AddrW-1:0]        core_addr_i, dbg_addr_i;
    logic [1:0]              core_op_i, dbg_op_i;
    logic [Width-1:0]        core_wdata_i, dbg_wdata_i;
    logic                    core_gnt_o, dbg_gnt_o, core_rvalid_o, dbg_rvalid_o;
    logic [Width-1:0]        rdata_o;
    logic                    err_o;
    logic [NumCsr-1:0]       csr_wr_en_o;
    logic [Width-1:0]        csr_wr_data_o;
    logic [NumCsr*Width-1:0] csr_rd_data_i;
    logic [NumCsr-1:0]       csr_rd_error_i;
    logic                    alert_o, busy_o;

    ibex_csr_access_arb #(.NumCsr(NumCsr), .Width(Width), .AddrW(AddrW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .core_req_i     (core_req_i),
        .core_addr_i    (core_addr_i),
        .core_op_i      (core_op_i),
        .core_wdata_i   (core_wdata_i),
        .core_gnt_o     (core_gnt_o),
        .core_rvalid_o  (core_rvalid_o),
        .dbg_req_i      (dbg_req_i),
        .dbg_addr_i     (dbg_addr_i),
        .dbg_op_i       (dbg_op_i),
        .dbg_wdata_i    (dbg_wdata_i),
        .dbg_gnt_o      (dbg_gnt_o),
        .dbg_rvalid_o   (dbg_rvalid_o),
        .rdata_o        (rdata_o),
        .err_o          (err_o),
        .csr_wr_en_o    (csr_wr_en_o),
        .csr_wr_data_o  (csr_wr_data_o),
        .csr_rd_data_i  (csr_rd_data_i),
        .csr_rd_error_i (csr_rd_error_i),
        .alert_o        (alert_o),
        .busy_o         (busy_o)
    );

    typedef struct {
        bit          dbg;
        logic [2:0]  addr;
        logic [1:0]  op;
        logic [31:0] wdata;
        logic [3:0]  rderr;
        logic [3:0]  exp_wen;
        logic [31:0] exp_wdat;
        logic [31:0] exp_rdata;
        bit          exp_err;
        bit          exp_alert;
    } vec_t;

    typedef struct {
        bit          dbg;
        logic [31:0] rdata;
        bit          err;
        bit          alert;
    } resp_t;

    resp_t       sb[$];
    int          checks = 0;
    int          fails  = 0;
    logic [31:0] bank [4] = '{32'h0, 32'h0, 32'h0000_00F0, 32'h0};
    vec_t        vecs [9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CSR instance model: written only by the DUT's enables.
    always @(posedge clk) begin
        for (int i = 0; i < NumCsr; i++)
            if (csr_wr_en_o[i]) bank[i] <= csr_wr_data_o;
    end

    always_comb begin
        for (int i = 0; i < NumCsr; i++)
            csr_rd_data_i[i*Width +: Width] = bank[i];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every rvalid.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (core_rvalid_o || dbg_rvalid_o) begin
                if (sb.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_rvalid actual=%b%b required=00", dbg_rvalid_o, core_rvalid_o);
                end else begin
                    resp_t e;
                    e = sb.pop_front();
                    chk("rvalid_owner", {dbg_rvalid_o, core_rvalid_o}, e.dbg ? 2'b10 : 2'b01);
                    chk("rdata", rdata_o, e.rdata);
                    chk("err", err_o, e.err);
                    chk("alert", alert_o, e.alert);
                end
            end else if (alert_o || err_o || rdata_o != '0) begin
                checks++; fails++;
                $display("FAIL idle_resp_outputs actual=%b/%b/0x%0h required=0/0/0", alert_o, err_o, rdata_o);
            end
        end
    end

    task automatic drive_idle();
        core_req_i = 0; core_addr_i = '0; core_op_i = 2'b00; core_wdata_i = '0;
        dbg_req_i  = 0; dbg_addr_i  = '0; dbg_op_i  = 2'b00; dbg_wdata_i  = '0;
        csr_rd_error_i = '0;
    endtask

    // Called at posedge+1 while the DUT is idle.
    task automatic do_vec(input vec_t v, input int idx);
        bit    got;
        resp_t e;
        csr_rd_error_i = v.rderr;
        if (v.dbg) begin
            dbg_req_i = 1; dbg_addr_i = v.addr; dbg_op_i = v.op; dbg_wdata_i = v.wdata;
        end else begin
            core_req_i = 1; core_addr_i = v.addr; core_op_i = v.op; core_wdata_i = v.wdata;
        end
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            got = v.dbg ? dbg_gnt_o : core_gnt_o;
        end
        chk($sformatf("v%0d_gnt", idx), {dbg_gnt_o, core_gnt_o}, v.dbg ? 2'b10 : 2'b01);
        chk($sformatf("v%0d_busy_G", idx), busy_o, 1'b0);
        if (got) begin
            e.dbg = v.dbg; e.rdata = v.exp_rdata; e.err = v.exp_err; e.alert = v.exp_alert;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        core_req_i = 0; dbg_req_i = 0;
        @(negedge clk);
        chk($sformatf("v%0d_busy_G1", idx), busy_o, 1'b1);
        chk($sformatf("v%0d_wen_G1", idx), csr_wr_en_o, 4'b0000);
        @(negedge clk);
        chk($sformatf("v%0d_wen_G2", idx), csr_wr_en_o, v.exp_wen);
        chk($sformatf("v%0d_wdat_G2", idx), csr_wr_data_o, v.exp_wdat);
        @(negedge clk);
        @(posedge clk); #1;
        csr_rd_error_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int    cyc, last_g;
        bit    got;
        resp_t e;

        //              dbg addr  op     wdata          rderr    wen      wdat           rdata          err alert
        vecs[0] = '{0, 3'd1, 2'b01, 32'hDEAD_BEEF, 4'b0000, 4'b0010, 32'hDEAD_BEEF, 32'h0,         0, 0};
        vecs[1] = '{0, 3'd2, 2'b10, 32'h0000_000F, 4'b0000, 4'b0100, 32'h0000_00FF, 32'h0000_00F0, 0, 0};
        vecs[2] = '{0, 3'd2, 2'b11, 32'h0000_00F0, 4'b0000, 4'b0100, 32'h0000_000F, 32'h0000_00FF, 0, 0};
        vecs[3] = '{0, 3'd2, 2'b10, 32'h0,         4'b0000, 4'b0000, 32'h0,         32'h0000_000F, 0, 0};
        vecs[4] = '{1, 3'd1, 2'b00, 32'h1234_5678, 4'b0000, 4'b0000, 32'h0,         32'hDEAD_BEEF, 0, 0};
        vecs[5] = '{1, 3'd3, 2'b01, 32'hCAFE_F00D, 4'b1000, 4'b0000, 32'h0,         32'h0,         1, 1};
        vecs[6] = '{0, 3'd5, 2'b01, 32'hAAAA_5555, 4'b0000, 4'b0000, 32'h0,         32'h0,         1, 0};
        vecs[7] = '{1, 3'd1, 2'b11, 32'hFFFF_0000, 4'b0000, 4'b0010, 32'h0000_BEEF, 32'hDEAD_BEEF, 0, 0};
        vecs[8] = '{1, 3'd2, 2'b00, 32'h0,         4'b0000, 4'b0000, 32'h0,         32'h0000_000F, 0, 0};

        drive_idle();
        rst_ni = 0;
        core_req_i = 1; dbg_req_i = 1;
        #3;
        chk("reset_ctrl", {core_gnt_o, dbg_gnt_o, core_rvalid_o, dbg_rvalid_o, err_o, alert_o, busy_o, csr_wr_en_o}, '0);
        chk("reset_rdata", rdata_o, '0);
        chk("reset_wdata", csr_wr_data_o, '0);
        core_req_i = 0; dbg_req_i = 0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1;

        for (int i = 0; i < 9; i++) do_vec(vecs[i], i);

        // Both requesters held: grants must alternate core/dbg every 4 cycles.
        core_req_i = 1; core_addr_i = 3'd0; core_op_i = 2'b00;
        dbg_req_i  = 1; dbg_addr_i  = 3'd1; dbg_op_i  = 2'b00;
        cyc = 0; last_g = 0;
        for (int g = 0; g < 4; g++) begin
            got = 0;
            for (int n = 0; n < 12 && !got; n++) begin
                @(negedge clk);
                cyc++;
                got = core_gnt_o | dbg_gnt_o;
            end
            chk($sformatf("rr%0d_gnt", g), {dbg_gnt_o, core_gnt_o}, (g % 2) ? 2'b10 : 2'b01);
            if (g > 0) chk($sformatf("rr%0d_interval", g), cyc - last_g, 4);
            last_g = cyc;
            if (got) begin
                e.dbg = dbg_gnt_o; e.rdata = dbg_gnt_o ? bank[1] : bank[0]; e.err = 0; e.alert = 0;
                sb.push_back(e);
            end
        end
        @(posedge clk); #1;
        drive_idle();
        repeat (4) @(negedge clk);
        @(posedge clk); #1;

        // Reset during WRITE drops the write and resets the round-robin pointer.
        core_req_i = 1; core_addr_i = 3'd0; core_op_i = 2'b01; core_wdata_i = 32'h1234_5678;
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            got = core_gnt_o;
        end
        chk("midop_gnt", core_gnt_o, 1'b1);
        if (got) begin
            e.dbg = 0; e.rdata = 32'h0; e.err = 0; e.alert = 0;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midop_wen_before_reset", csr_wr_en_o, 4'b0001);
        rst_ni = 0;
        core_op_i = 2'b00;
        dbg_req_i = 1; dbg_addr_i = 3'd1; dbg_op_i = 2'b00;
        #1;
        chk("midop_reset_ctrl", {core_gnt_o, dbg_gnt_o, core_rvalid_o, dbg_rvalid_o, err_o, alert_o, busy_o, csr_wr_en_o}, '0);
        chk("midop_reset_wdata", csr_wr_data_o, '0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midop_csr0_unwritten", bank[0], 32'h0);
        @(posedge clk); #1;
        rst_ni = 1;
        @(negedge clk);
        chk("post_reset_gnt", {dbg_gnt_o, core_gnt_o}, 2'b01);
        if (core_gnt_o) begin
            e.dbg = 0; e.rdata = bank[0]; e.err = 0; e.alert = 0;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        drive_idle();
        repeat (5) @(negedge clk);

        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/ibex_csr_access_arb.md
# ibex_csr_access_arb

Sequencer and arbiter sharing a bank of `NumCsr` CSR primitives between two requesters: the core CSR pipeline (port `core`) and the debug module (port `dbg`). Each access is a serialized read-check-modify-write: the old value is read and shadow-checked, the new value is computed (write/set/clear), and at most one single-cycle write enable is issued. The block sits between the decoder/debug interfaces and the CSR register instances, and it owns the alert path for shadow mismatches.

## Interface
- `NumCsr`, default 4: number of CSR instances; must be at least 2.
- `Width`, default 32: CSR data width.
- `AddrW`, default 3: request address width; must satisfy 2^AddrW > NumCsr so that out-of-range addresses are representable.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `core_req_i` / `dbg_req_i`, in, 1: access request, held until granted.
- `core_addr_i` / `dbg_addr_i`, in, AddrW: CSR index.
- `core_op_i` / `dbg_op_i`, in, 2: 00 READ, 01 WRITE, 10 SET, 11 CLEAR.
- `core_wdata_i` / `dbg_wdata_i`, in, Width: write data or bit mask.
- `core_gnt_o` / `dbg_gnt_o`, out, 1: request accepted this cycle (combinational, IDLE only).
- `core_rvalid_o` / `dbg_rvalid_o`, out, 1: one-cycle response pulse.
- `rdata_o`, out, Width: old CSR value; valid with rvalid, 0 otherwise.
- `err_o`, out, 1: response error flag; valid with rvalid.
- `csr_wr_en_o`, out, NumCsr: one-hot write enables to the CSR instances.
- `csr_wr_data_o`, out, Width: shared write data; 0 outside WRITE.
- `csr_rd_data_i`, in, NumCsr*Width: CSR read data; instance i occupies bits [i*Width +: Width].
- `csr_rd_error_i`, in, NumCsr: shadow mismatch per CSR.
- `alert_o`, out, 1: one-cycle pulse on shadow mismatch.
- `busy_o`, out, 1: FSM is not in IDLE.

## Operation
- FSM states: IDLE → READ → WRITE → RESP → IDLE.
- IDLE: when any request is present, grant exactly one requester. The block latches the owner, address, op and wdata, then moves to READ.
- Arbitration: round-robin. If both requesters are active, grant the one not granted last. After reset, last-granted = dbg, so core wins the first tie. A lone requester is always granted.
- READ: for in-range addresses, capture `old = csr_rd_data_i[addr]` and sample `csr_rd_error_i[addr]`.
- Computed new value:
  - WRITE: `wdata`
  - SET: `old | wdata`
  - CLEAR: `old & ~wdata`
- Write is suppressed in any of these cases:
  - op is READ;
  - op is SET or CLEAR with `wdata == 0`;
  - address is out of range (addr ≥ NumCsr);
  - a shadow error was sampled.
- WRITE: if not suppressed, assert `csr_wr_en_o[addr]` and drive `csr_wr_data_o` = new value. Otherwise no enable is asserted and data stays 0. The state is visited in both cases.
- RESP: pulse the owner's rvalid.
  - `rdata_o` = old value, or 0 if the address is out of range.
  - `err_o` = 1 on out-of-range address or shadow error.
- Shadow error: `alert_o` pulses in the RESP cycle. Out-of-range addresses set `err_o` only and do not pulse `alert_o`.
- There is no response backpressure; requesters must accept rvalid when it arrives.
- Asynchronous reset at any point:
  - FSM returns to IDLE and any in-flight write is dropped;
  - all outputs go to 0;
  - the round-robin pointer resets.

## Timing
- Reset values: every output is 0 (gnt, rvalid, rdata, err, wr_en, wr_data, alert, busy).
- Grant in cycle G (combinational from req, IDLE only).
- READ in G+1. WRITE in G+2: wr_en is high for exactly one cycle, and the CSR is updated at the end of G+2.
- RESP in G+3. The next grant is possible in G+4, giving a throughput of one access per 4 cycles.
- `busy_o` is high during G+1 through G+3.
- Requests arriving while busy are ignored (no gnt) until IDLE.
- At most one bit of `csr_wr_en_o` is ever set.

## Test plan
- Core WRITE to addr 1 with wdata 0xDEADBEEF, CSR previously 0:
  - gnt in G; wr_en_o = 0b0010 with data 0xDEADBEEF in G+2;
  - core_rvalid in G+3 with rdata 0, err 0.
- SET then CLEAR: CSR2 = 0x00F0.
  - SET with mask 0x000F writes 0x00FF.
  - CLEAR with mask 0x00F0 writes 0x000F; rdata returns 0x00FF.
  - SET with mask 0 produces no wr_en; rdata returns 0x000F.
- Simultaneous core and dbg requests, held continuously:
  - grants alternate core, dbg, core, dbg at cycles G, G+4, G+8, G+12;
  - rvalid goes only to the owner.
- Shadow error: force `csr_rd_error_i[3]=1` and issue a WRITE to addr 3.
  - No wr_en.
  - In RESP: err_o=1 and alert_o high for one cycle.
- Out-of-range: NumCsr=4, addr 5, op WRITE.
  - No wr_en; rdata 0, err 1, alert 0.
- Reset mid-op: assert rst_ni low during WRITE.
  - All outputs 0 immediately; the CSR is not written.
  - After release with both requesters active, core is granted first.
